// File: rtl/usb_device_rx_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : usb_device_rx_decoder
// Purpose  : USB device receive front end - oversampled bit recovery, NRZI
//            decode, bit unstuffing, SYNC/EOP framing and bus-reset detect.
// Revision : 1.0 - initial release
// ============================================================================
module usb_device_rx_decoder #(
   parameter int CLK_DIV   = 32,
   parameter int RST_BITS  = 30,
   parameter int LOW_SPEED = 0
) (
   input  logic       i_clk_ref,
   input  logic       i_reset,
   input  logic       i_dp,
   input  logic       i_dm,
   input  logic       i_rx_en,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_rx_active,
   output logic       o_rx_eop,
   output logic       o_rx_err,
   output logic [1:0] o_line_state,
   output logic       o_bus_reset
);

   localparam int                c_PH_W    = $clog2(CLK_DIV);
   localparam int                c_RC_W    = $clog2(RST_BITS + 1);
   localparam logic [c_PH_W-1:0] c_PH_MID  = c_PH_W'(CLK_DIV / 2);
   localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(CLK_DIV - 1);
   localparam logic [c_RC_W-1:0] c_RST_CNT = c_RC_W'(RST_BITS);
   localparam logic              c_J_DP    = (LOW_SPEED == 0) ? 1'b1 : 1'b0;
   localparam logic [1:0]        c_LS_SE0  = 2'd0;
   localparam logic [1:0]        c_LS_J    = 2'd1;
   localparam logic [1:0]        c_LS_K    = 2'd2;
   localparam logic [1:0]        c_LS_SE1  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SYNC  = 3'd1,
      S_DATA  = 3'd2,
      S_EOP   = 3'd3,
      S_ABORT = 3'd4
   } state_t;

   // ---------------------------------------------------------------- front end
   logic              r_dp_s1, r_dp_s2, r_dm_s1, r_dm_s2;
   logic [c_PH_W-1:0] r_phase;
   logic              r_prev_k;
   logic [2:0]        r_ones;
   logic [c_RC_W-1:0] r_se0_cnt;
   logic [1:0]        w_line;
   logic              w_change, w_strobe, w_bit;
   logic              w_is_j, w_is_k, w_is_se0, w_is_se1;

   always_comb begin
      w_line = c_LS_J;
      case ({r_dp_s2, r_dm_s2})
         2'b00:   w_line = c_LS_SE0;
         2'b11:   w_line = c_LS_SE1;
         2'b10:   w_line = c_J_DP ? c_LS_J : c_LS_K;
         default: w_line = c_J_DP ? c_LS_K : c_LS_J;
      endcase
   end

   assign w_is_j   = (w_line == c_LS_J);
   assign w_is_k   = (w_line == c_LS_K);
   assign w_is_se0 = (w_line == c_LS_SE0);
   assign w_is_se1 = (w_line == c_LS_SE1);
   assign w_change = (r_dp_s1 != r_dp_s2) || (r_dm_s1 != r_dm_s2);
   assign w_strobe = (r_phase == c_PH_MID);
   assign w_bit    = (w_is_k == r_prev_k);

   always_ff @(posedge i_clk_ref or posedge i_reset) begin
      if (i_reset) begin
         r_dp_s1   <= c_J_DP;
         r_dp_s2   <= c_J_DP;
         r_dm_s1   <= ~c_J_DP;
         r_dm_s2   <= ~c_J_DP;
         r_phase   <= '0;
         r_prev_k  <= 1'b0;
         r_ones    <= 3'd0;
         r_se0_cnt <= '0;
      end else begin
         // Floating/unknown lines resolve to the pulled idle levels
         r_dp_s1 <= (i_dp !== 1'b0);
         r_dm_s1 <= (i_dm === 1'b1);
         r_dp_s2 <= r_dp_s1;
         r_dm_s2 <= r_dm_s1;
         if (w_change || (r_phase == c_PH_LAST))
            r_phase <= '0;
         else
            r_phase <= r_phase + 1'b1;
         if (w_strobe) begin
            r_prev_k <= w_is_k;
            if ((w_is_j || w_is_k) && w_bit) begin
               if (r_ones != 3'd7)
                  r_ones <= r_ones + 3'd1;
            end else begin
               r_ones <= 3'd0;
            end
            if (!w_is_se0)
               r_se0_cnt <= '0;
            else if (r_se0_cnt != c_RST_CNT)
               r_se0_cnt <= r_se0_cnt + 1'b1;
         end
      end
   end

   assign o_line_state = w_line;
   assign o_bus_reset  = (r_se0_cnt == c_RST_CNT);

   // ---------------------------------------------------------------- framing
   state_t     r_state, w_state_nxt;
   logic [2:0] r_zero_cnt, w_zero_nxt;
   logic [2:0] r_bit_cnt, w_bitcnt_nxt;
   logic [6:0] r_shift, w_shift_nxt;
   logic       r_eop_err, w_eop_err_nxt;
   logic [2:0] r_j_cnt, w_j_nxt;
   logic       r_seen_se0, w_seen_se0_nxt;
   logic [7:0] r_rx_data, w_data_nxt;
   logic       r_rx_valid, r_rx_err, r_rx_eop;
   logic       w_valid_nxt, w_err_nxt, w_eop_nxt, w_abort;

   always_ff @(posedge i_clk_ref or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_zero_cnt <= 3'd0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 7'd0;
         r_eop_err  <= 1'b0;
         r_j_cnt    <= 3'd0;
         r_seen_se0 <= 1'b0;
         r_rx_data  <= 8'd0;
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
         r_rx_eop   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_zero_cnt <= w_zero_nxt;
         r_bit_cnt  <= w_bitcnt_nxt;
         r_shift    <= w_shift_nxt;
         r_eop_err  <= w_eop_err_nxt;
         r_j_cnt    <= w_j_nxt;
         r_seen_se0 <= w_seen_se0_nxt;
         r_rx_data  <= w_data_nxt;
         r_rx_valid <= w_valid_nxt;
         r_rx_err   <= w_err_nxt;
         r_rx_eop   <= w_eop_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_zero_nxt     = r_zero_cnt;
      w_bitcnt_nxt   = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_eop_err_nxt  = r_eop_err;
      w_j_nxt        = r_j_cnt;
      w_seen_se0_nxt = r_seen_se0;
      w_data_nxt     = r_rx_data;
      w_valid_nxt    = 1'b0;
      w_err_nxt      = 1'b0;
      w_eop_nxt      = 1'b0;
      w_abort        = 1'b0;
      if (w_strobe) begin
         case (r_state)
            S_IDLE: begin
               // The leading K is itself the first SYNC zero
               if (w_is_k) begin
                  w_state_nxt = S_SYNC;
                  w_zero_nxt  = 3'd1;
               end
            end
            S_SYNC: begin
               if (w_is_se0)
                  w_state_nxt = S_IDLE;
               else if (w_is_se1)
                  w_abort = 1'b1;
               else if (!w_bit) begin
                  if (r_zero_cnt != 3'd7)
                     w_zero_nxt = r_zero_cnt + 3'd1;
               end else if (r_zero_cnt >= 3'd5) begin
                  w_state_nxt   = S_DATA;
                  w_bitcnt_nxt  = 3'd0;
                  w_eop_err_nxt = 1'b0;
               end else
                  w_abort = 1'b1;
            end
            S_DATA: begin
               if (w_is_se0) begin
                  w_state_nxt   = S_EOP;
                  w_eop_err_nxt = (r_bit_cnt != 3'd0);
                  w_err_nxt     = (r_bit_cnt != 3'd0);
               end else if (w_is_se1)
                  w_abort = 1'b1;
               else if (r_ones == 3'd6) begin
                  // Bit after six ones must be a stuffed zero, which is dropped
                  if (w_bit)
                     w_abort = 1'b1;
               end else begin
                  w_shift_nxt  = {w_bit, r_shift[6:1]};
                  w_bitcnt_nxt = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     w_valid_nxt = 1'b1;
                     w_data_nxt  = {w_bit, r_shift};
                  end
               end
            end
            S_EOP: begin
               if (w_is_j) begin
                  w_state_nxt = S_IDLE;
                  w_eop_nxt   = !r_eop_err;
               end else if (!w_is_se0)
                  w_abort = 1'b1;
            end
            S_ABORT: begin
               if (w_is_j) begin
                  if (r_seen_se0 || (r_j_cnt == 3'd7))
                     w_state_nxt = S_IDLE;
                  else
                     w_j_nxt = r_j_cnt + 3'd1;
               end else begin
                  w_j_nxt        = 3'd0;
                  w_seen_se0_nxt = w_is_se0;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
         if (w_abort) begin
            w_state_nxt    = S_ABORT;
            w_err_nxt      = 1'b1;
            w_j_nxt        = 3'd0;
            w_seen_se0_nxt = 1'b0;
         end
      end
      if (!i_rx_en || o_bus_reset) begin
         w_state_nxt = S_IDLE;
         w_valid_nxt = 1'b0;
         w_err_nxt   = 1'b0;
         w_eop_nxt   = 1'b0;
      end
   end

   assign o_rx_data   = r_rx_data;
   assign o_rx_valid  = r_rx_valid;
   assign o_rx_err    = r_rx_err;
   assign o_rx_eop    = r_rx_eop;
   assign o_rx_active = (r_state == S_DATA) || (r_state == S_EOP);

endmodule
`default_nettype wire

// File: tb/tb_usb_device_rx_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_usb_device_rx_decoder
// Purpose  : Self-checking bench; encodes packets on Dp/Dm, scoreboards events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_device_rx_decoder;

   localparam int         CLK_DIV  = 32;
   localparam int         RST_BITS = 30;
   localparam logic [1:0] EV_BYTE  = 2'd0;
   localparam logic [1:0] EV_EOP   = 2'd1;
   localparam logic [1:0] EV_ERR   = 2'd2;

   logic       clk = 1'b0;
   logic       reset, dp, dm, rx_en;
   logic [7:0] rx_data;
   logic       rx_valid, rx_active, rx_eop, rx_err, bus_reset;
   logic [1:0] line_state;

   int         err_cnt = 0;
   int         chk_cnt = 0;
   logic [9:0] exp_q[$];
   logic       line_k;
   int         ones;
   logic [15:0] pat;

   usb_device_rx_decoder #(
      .CLK_DIV  (CLK_DIV),
      .RST_BITS (RST_BITS),
      .LOW_SPEED(0)
   ) u_dut (
      .i_clk_ref   (clk),
      .i_reset     (reset),
      .i_dp        (dp),
      .i_dm        (dm),
      .i_rx_en     (rx_en),
      .o_rx_data   (rx_data),
      .o_rx_valid  (rx_valid),
      .o_rx_active (rx_active),
      .o_rx_eop    (rx_eop),
      .o_rx_err    (rx_err),
      .o_line_state(line_state),
      .o_bus_reset (bus_reset)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic take_event(input logic [9:0] ev);
      if (exp_q.size() == 0)
         chk("unexpected_event", 32'(ev), 32'h3FF);
      else
         chk("event", 32'(ev), 32'(exp_q.pop_front()));
   endtask

   always @(negedge clk) begin
      if (rx_valid) take_event({EV_BYTE, rx_data});
      if (rx_eop)   take_event({EV_EOP, 8'h00});
      if (rx_err)   take_event({EV_ERR, 8'h00});
   end

   // Full speed: J = (dp=1,dm=0), K = (dp=0,dm=1)
   task automatic drive(input logic dpv, input logic dmv, input int per);
      dp = dpv;
      dm = dmv;
      repeat (per) @(negedge clk);
   endtask

   task automatic put_lvl(input int per);
      drive(!line_k, line_k, per);
   endtask

   task automatic put_bit(input logic b, input int per, input bit stuff);
      if (!b) line_k = !line_k;
      put_lvl(per);
      ones = b ? ones + 1 : 0;
      if (stuff && ones == 6) begin
         line_k = !line_k;
         put_lvl(per);
         ones = 0;
      end
   endtask

   task automatic send_sync(input int per);
      line_k = 1'b0;
      ones   = 0;
      for (int i = 0; i < 8; i++) put_bit(i == 7, per, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int per, input bit stuff);
      for (int i = 0; i < 8; i++) put_bit(b[i], per, stuff);
   endtask

   task automatic send_eop(input int per);
      drive(1'b0, 1'b0, 2 * per);
      line_k = 1'b0;
      put_lvl(per);
   endtask

   task automatic idle(input int nbits);
      line_k = 1'b0;
      put_lvl(nbits * CLK_DIV);
   endtask

   initial begin
      reset = 1'b1;
      rx_en = 1'b1;
      dp    = 1'b1;
      dm    = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_line_state", 32'(line_state), 32'd1);
      chk("rst_active",     32'(rx_active),  32'd0);
      chk("rst_valid",      32'(rx_valid),   32'd0);
      chk("rst_data",       32'(rx_data),    32'd0);
      chk("rst_bus_reset",  32'(bus_reset),  32'd0);
      chk("rst_pulses",     32'({rx_eop, rx_err}), 32'd0);
      reset = 1'b0;
      idle(4);

      // Basic packet
      exp_q.push_back({EV_BYTE, 8'hA5});
      exp_q.push_back({EV_EOP, 8'h00});
      send_sync(CLK_DIV);
      chk("active_after_sync", 32'(rx_active), 32'd1);
      send_byte(8'hA5, CLK_DIV, 1'b1);
      send_eop(CLK_DIV);
      chk("active_after_eop", 32'(rx_active), 32'd0);
      idle(2);

      // Stuffed zero inserted inside 0xFF
      exp_q.push_back({EV_BYTE, 8'hFF});
      exp_q.push_back({EV_BYTE, 8'h01});
      exp_q.push_back({EV_EOP, 8'h00});
      send_sync(CLK_DIV);
      send_byte(8'hFF, CLK_DIV, 1'b1);
      send_byte(8'h01, CLK_DIV, 1'b1);
      send_eop(CLK_DIV);
      idle(2);

      // Missing stuff bit
      exp_q.push_back({EV_ERR, 8'h00});
      send_sync(CLK_DIV);
      send_byte(8'hFF, CLK_DIV, 1'b0);
      chk("active_after_stuff_err", 32'(rx_active), 32'd0);
      send_eop(CLK_DIV);
      idle(10);

      // EOP after 12 data bits
      exp_q.push_back({EV_BYTE, 8'h96});
      exp_q.push_back({EV_ERR, 8'h00});
      pat = 16'h0A96;
      send_sync(CLK_DIV);
      for (int i = 0; i < 12; i++) put_bit(pat[i], CLK_DIV, 1'b1);
      send_eop(CLK_DIV);
      chk("active_after_bad_eop", 32'(rx_active), 32'd0);
      idle(2);

      // Bit-period drift
      exp_q.push_back({EV_BYTE, 8'h3C});
      exp_q.push_back({EV_BYTE, 8'hC3});
      exp_q.push_back({EV_BYTE, 8'h5A});
      exp_q.push_back({EV_EOP, 8'h00});
      send_sync(CLK_DIV);
      send_byte(8'h3C, CLK_DIV + 2, 1'b1);
      send_byte(8'hC3, CLK_DIV - 2, 1'b1);
      send_byte(8'h5A, CLK_DIV + 2, 1'b1);
      send_eop(CLK_DIV + 2);
      idle(2);

      // Receiver disabled: line ignored
      rx_en = 1'b0;
      send_sync(CLK_DIV);
      chk("active_rx_dis", 32'(rx_active), 32'd0);
      send_byte(8'hA5, CLK_DIV, 1'b1);
      send_eop(CLK_DIV);
      rx_en = 1'b1;
      idle(2);

      // Bus reset: 31 bit times of SE0, 30th sample lands ~947 clocks in
      dp = 1'b0;
      dm = 1'b0;
      repeat (940) @(negedge clk);
      chk("line_state_se0",   32'(line_state), 32'd0);
      chk("bus_reset_before", 32'(bus_reset),  32'd0);
      repeat (10) @(negedge clk);
      chk("bus_reset_set",    32'(bus_reset),  32'd1);
      repeat (31 * CLK_DIV - 950) @(negedge clk);
      chk("bus_reset_held",   32'(bus_reset),  32'd1);
      line_k = 1'b0;
      put_lvl(40);
      chk("bus_reset_clear",  32'(bus_reset),  32'd0);
      chk("line_state_j",     32'(line_state), 32'd1);
      idle(4);

      // Reset pulse mid-byte
      send_sync(CLK_DIV);
      for (int i = 0; i < 4; i++) put_bit(i[0], CLK_DIV, 1'b1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_active", 32'(rx_active),  32'd0);
      chk("mid_rst_data",   32'(rx_data),    32'd0);
      chk("mid_rst_line",   32'(line_state), 32'd1);
      chk("mid_rst_pulses", 32'({rx_valid, rx_eop, rx_err}), 32'd0);
      dp    = 1'b1;
      dm    = 1'b0;
      reset = 1'b0;
      idle(4);

      // Recovery after reset
      exp_q.push_back({EV_BYTE, 8'h5A});
      exp_q.push_back({EV_EOP, 8'h00});
      send_sync(CLK_DIV);
      send_byte(8'h5A, CLK_DIV, 1'b1);
      send_eop(CLK_DIV);
      idle(2);

      chk("events_left", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
